// File: rtl/blt_vramctrl.sv
// VRAM access engine: walks the clipped destination rectangle row-major and issues
// single-word VRAM writes (PatBlt) or read/write pairs (BitBlt), one request at a time.
module blt_vramctrl #(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 14,
  parameter int unsigned H_W = 10
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 INIT,
  input  logic                 STARTBLT,
  input  logic [1:0]           VALID,
  input  logic [X_W-1:0]       OVA_SPOSX,
  input  logic [Y_W-1:0]       OVA_SPOSY,
  input  logic [X_W-1:0]       OVA_DPOSX,
  input  logic [Y_W-1:0]       OVA_DPOSY,
  input  logic [X_W-1:0]       OVA_WIDTH,
  input  logic [H_W-1:0]       OVA_HEIGHT,
  input  logic [15:0]          PAT_COLOR,
  input  logic                 VRAM_ACK,
  input  logic [31:0]          VRAM_RDATA,
  output logic                 VRAM_REQ,
  output logic                 VRAM_WE,
  output logic [Y_W+X_W-1:0]   VRAM_ADR,
  output logic [31:0]          VRAM_WDATA,
  output logic                 BUSY_VRAMCTRL,
  output logic                 DONE,
  output logic                 ERROR
);

  localparam int unsigned A_W = Y_W + X_W;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD, S_RDW, S_WR, S_WRW, S_FIN} state_t;

  state_t            r_state, w_state_n;
  logic              r_req, w_req_n, r_we, w_we_n;
  logic [A_W-1:0]    r_adr, w_adr_n;
  logic [31:0]       r_wdata, w_wdata_n, r_rdata, w_rdata_n;
  logic              r_busy, w_busy_n, r_done, w_done_n, r_error, w_error_n;
  logic [X_W-1:0]    r_cx, w_cx_n, r_sposx, w_sposx_n, r_dposx, w_dposx_n, r_width, w_width_n;
  logic [H_W-1:0]    r_cy, w_cy_n, r_height, w_height_n;
  logic [Y_W-1:0]    r_sposy, w_sposy_n, r_dposy, w_dposy_n;
  logic              r_bitblt, w_bitblt_n;
  logic [15:0]       r_color, w_color_n;

  logic              w_row_end, w_last;
  logic [A_W-1:0]    w_src_adr, w_dst_adr;

  // Column sums wrap inside the column field; no carry into the row.
  assign w_src_adr = {Y_W'(r_sposy + Y_W'(r_cy)), X_W'(r_sposx + r_cx)};
  assign w_dst_adr = {Y_W'(r_dposy + Y_W'(r_cy)), X_W'(r_dposx + r_cx)};
  assign w_row_end = (r_cx == X_W'(r_width - X_W'(1)));
  assign w_last    = w_row_end && (r_cy == H_W'(r_height - H_W'(1)));

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_sposx  <= '0;
      r_sposy  <= '0;
      r_dposx  <= '0;
      r_dposy  <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_bitblt <= 1'b0;
      r_color  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_req    <= w_req_n;
      r_we     <= w_we_n;
      r_adr    <= w_adr_n;
      r_wdata  <= w_wdata_n;
      r_rdata  <= w_rdata_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_error  <= w_error_n;
      r_cx     <= w_cx_n;
      r_cy     <= w_cy_n;
      r_sposx  <= w_sposx_n;
      r_sposy  <= w_sposy_n;
      r_dposx  <= w_dposx_n;
      r_dposy  <= w_dposy_n;
      r_width  <= w_width_n;
      r_height <= w_height_n;
      r_bitblt <= w_bitblt_n;
      r_color  <= w_color_n;
    end
  end

  // Next-state and registered-output logic; request outputs are staged one cycle ahead.
  always_comb begin
    w_state_n  = r_state;
    w_req_n    = r_req;
    w_we_n     = r_we;
    w_adr_n    = r_adr;
    w_wdata_n  = r_wdata;
    w_rdata_n  = r_rdata;
    w_error_n  = 1'b0;
    w_cx_n     = r_cx;
    w_cy_n     = r_cy;
    w_sposx_n  = r_sposx;
    w_sposy_n  = r_sposy;
    w_dposx_n  = r_dposx;
    w_dposy_n  = r_dposy;
    w_width_n  = r_width;
    w_height_n = r_height;
    w_bitblt_n = r_bitblt;
    w_color_n  = r_color;

    case (r_state)
      S_IDLE: begin
        if (STARTBLT) begin
          if (VALID == 2'b01 || VALID == 2'b10) begin
            w_sposx_n  = OVA_SPOSX;
            w_sposy_n  = OVA_SPOSY;
            w_dposx_n  = OVA_DPOSX;
            w_dposy_n  = OVA_DPOSY;
            w_width_n  = OVA_WIDTH;
            w_height_n = OVA_HEIGHT;
            w_bitblt_n = VALID[1];
            w_color_n  = PAT_COLOR;
            w_state_n  = S_SETUP;
          end else if (VALID == 2'b11) begin
            w_error_n  = 1'b1;
          end
        end
      end
      S_SETUP: begin
        w_cx_n = '0;
        w_cy_n = '0;
        if (r_width == '0 || r_height == '0) w_state_n = S_FIN;
        else if (r_bitblt)                   w_state_n = S_RD;
        else                                 w_state_n = S_WR;
      end
      S_RD: begin
        w_req_n   = 1'b1;
        w_we_n    = 1'b0;
        w_adr_n   = w_src_adr;
        w_wdata_n = '0;
        w_state_n = S_RDW;
      end
      S_RDW: begin
        if (VRAM_ACK && r_req) begin
          w_rdata_n = VRAM_RDATA;
          w_req_n   = 1'b0;
          w_adr_n   = '0;
          w_state_n = S_WR;
        end
      end
      S_WR: begin
        w_req_n   = 1'b1;
        w_we_n    = 1'b1;
        w_adr_n   = w_dst_adr;
        w_wdata_n = r_bitblt ? r_rdata : {r_color, r_color};
        w_state_n = S_WRW;
      end
      S_WRW: begin
        if (VRAM_ACK && r_req) begin
          w_req_n   = 1'b0;
          w_we_n    = 1'b0;
          w_adr_n   = '0;
          w_wdata_n = '0;
          if (w_row_end) begin
            w_cx_n = '0;
            w_cy_n = H_W'(r_cy + H_W'(1));
          end else begin
            w_cx_n = X_W'(r_cx + X_W'(1));
          end
          if (w_last)        w_state_n = S_FIN;
          else if (r_bitblt) w_state_n = S_RD;
          else               w_state_n = S_WR;
        end
      end
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Abort wins over everything, including a pending ACK.
    if (INIT) begin
      w_state_n = S_IDLE;
      w_req_n   = 1'b0;
      w_we_n    = 1'b0;
      w_adr_n   = '0;
      w_wdata_n = '0;
      w_error_n = 1'b0;
    end

    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_FIN);
  end

  assign VRAM_REQ      = r_req;
  assign VRAM_WE       = r_we;
  assign VRAM_ADR      = r_adr;
  assign VRAM_WDATA    = r_wdata;
  assign BUSY_VRAMCTRL = r_busy;
  assign DONE          = r_done;
  assign ERROR         = r_error;

endmodule

// File: tb/tb_blt_vramctrl.sv
// Bench for blt_vramctrl: a rectangle-scan model predicts every VRAM access, a
// randomised-latency responder acknowledges requests, and a monitor checks each cycle.
module tb_blt_vramctrl;

  typedef struct packed {
    logic        we;
    logic [22:0] adr;
    logic [31:0] wdata;
  } acc_t;

  logic        CLK, RST_X, INIT, STARTBLT;
  logic [1:0]  VALID;
  logic [8:0]  OVA_SPOSX, OVA_DPOSX, OVA_WIDTH;
  logic [13:0] OVA_SPOSY, OVA_DPOSY;
  logic [9:0]  OVA_HEIGHT;
  logic [15:0] PAT_COLOR;
  logic        VRAM_ACK;
  logic [31:0] VRAM_RDATA;
  logic        VRAM_REQ, VRAM_WE, BUSY_VRAMCTRL, DONE, ERROR;
  logic [22:0] VRAM_ADR;
  logic [31:0] VRAM_WDATA;

  blt_vramctrl dut (
    .CLK(CLK), .RST_X(RST_X), .INIT(INIT), .STARTBLT(STARTBLT), .VALID(VALID),
    .OVA_SPOSX(OVA_SPOSX), .OVA_SPOSY(OVA_SPOSY), .OVA_DPOSX(OVA_DPOSX),
    .OVA_DPOSY(OVA_DPOSY), .OVA_WIDTH(OVA_WIDTH), .OVA_HEIGHT(OVA_HEIGHT),
    .PAT_COLOR(PAT_COLOR), .VRAM_ACK(VRAM_ACK), .VRAM_RDATA(VRAM_RDATA),
    .VRAM_REQ(VRAM_REQ), .VRAM_WE(VRAM_WE), .VRAM_ADR(VRAM_ADR),
    .VRAM_WDATA(VRAM_WDATA), .BUSY_VRAMCTRL(BUSY_VRAMCTRL), .DONE(DONE), .ERROR(ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0, errors = 0;
  int   busy_cnt = 0, done_cnt = 0, err_cnt = 0;
  acc_t exp_q[$];
  acc_t log_q[$];

  int unsigned dly_min = 1, dly_max = 1;
  logic hold = 1'b0, resp_ack = 1'b0, spur_ack = 1'b0;
  assign VRAM_ACK = resp_ack | spur_ack;

  function automatic logic [31:0] tag(input logic [22:0] a);
    return {9'h1A5, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected access list straight from the rectangle: row-major, reads precede writes.
  task automatic build_model(input logic bb, input logic [8:0] sx, input logic [13:0] sy,
                             input logic [8:0] dx, input logic [13:0] dy, input logic [8:0] w,
                             input logic [9:0] h, input logic [15:0] col);
    logic [22:0] ra, wa;
    for (int y = 0; y < int'(h); y++) begin
      for (int x = 0; x < int'(w); x++) begin
        ra = {14'(int'(sy) + y), 9'(int'(sx) + x)};
        wa = {14'(int'(dy) + y), 9'(int'(dx) + x)};
        if (bb) begin
          exp_q.push_back('{we: 1'b0, adr: ra, wdata: 32'h0});
          exp_q.push_back('{we: 1'b1, adr: wa, wdata: tag(ra)});
        end else begin
          exp_q.push_back('{we: 1'b1, adr: wa, wdata: {col, col}});
        end
      end
    end
  endtask

  // Memory responder with programmable latency; read data is tagged with its address.
  initial begin
    int unsigned d;
    VRAM_RDATA = '0;
    forever begin
      @(posedge CLK); #1;
      resp_ack = 1'b0;
      if (VRAM_REQ && !hold) begin
        d = $urandom_range(dly_max, dly_min);
        repeat (d) begin @(posedge CLK); #1; end
        resp_ack   = 1'b1;
        VRAM_RDATA = tag(VRAM_ADR);
      end
    end
  end

  // Per-cycle monitor: handshake rules, request ordering against the model, pulse counts.
  initial begin
    logic p_req, p_ack, p_init, p_we;
    logic [22:0] p_adr;
    logic [31:0] p_wdata;
    acc_t e, a;
    p_req = 0; p_ack = 0; p_init = 0; p_we = 0; p_adr = '0; p_wdata = '0;
    forever begin
      @(negedge CLK);
      if (RST_X) begin
        if (BUSY_VRAMCTRL) busy_cnt++;
        if (DONE) done_cnt++;
        if (ERROR) err_cnt++;
        if (VRAM_REQ) chk("req_implies_busy", 64'(BUSY_VRAMCTRL), 64'd1);
        if (p_req && !p_ack && !p_init) begin
          chk("req_held", 64'(VRAM_REQ), 64'd1);
          chk("adr_stable", 64'(VRAM_ADR), 64'(p_adr));
          chk("we_stable", 64'(VRAM_WE), 64'(p_we));
          chk("wdata_stable", 64'(VRAM_WDATA), 64'(p_wdata));
        end
        if (p_req && p_ack) chk("req_drop_after_ack", 64'(VRAM_REQ), 64'd0);
        if (VRAM_REQ && !p_req) begin
          a = '{we: VRAM_WE, adr: VRAM_ADR, wdata: VRAM_WDATA};
          log_q.push_back(a);
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 64'(VRAM_ADR), 64'h7FFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("acc_we", 64'(VRAM_WE), 64'(e.we));
            chk("acc_adr", 64'(VRAM_ADR), 64'(e.adr));
            if (e.we) chk("acc_wdata", 64'(VRAM_WDATA), 64'(e.wdata));
          end
        end
        p_req = VRAM_REQ; p_ack = VRAM_ACK; p_init = INIT;
        p_we = VRAM_WE; p_adr = VRAM_ADR; p_wdata = VRAM_WDATA;
      end
    end
  end

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    log_q.delete();
  endtask

  task automatic start_cmd(input logic [1:0] v, input logic [8:0] sx, input logic [13:0] sy,
                           input logic [8:0] dx, input logic [13:0] dy, input logic [8:0] w,
                           input logic [9:0] h, input logic [15:0] col);
    @(posedge CLK); #1;
    STARTBLT = 1'b1; VALID = v;
    OVA_SPOSX = sx; OVA_SPOSY = sy; OVA_DPOSX = dx; OVA_DPOSY = dy;
    OVA_WIDTH = w; OVA_HEIGHT = h; PAT_COLOR = col;
    @(posedge CLK); #1;
    STARTBLT = 1'b0; VALID = 2'b00;
    OVA_SPOSX = 9'($urandom); OVA_SPOSY = 14'($urandom); OVA_DPOSX = 9'($urandom);
    OVA_DPOSY = 14'($urandom); OVA_WIDTH = 9'($urandom); OVA_HEIGHT = 10'($urandom);
    PAT_COLOR = 16'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
      n++;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic finish_checks(input string nm, input int exp_busy);
    repeat (2) @(negedge CLK);
    chk({nm, "_busy_end"}, 64'(BUSY_VRAMCTRL), 64'd0);
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_err_cnt"}, 64'(err_cnt), 64'd0);
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  task automatic run_blt(input string nm, input logic [1:0] v, input logic [8:0] sx,
                         input logic [13:0] sy, input logic [8:0] dx, input logic [13:0] dy,
                         input logic [8:0] w, input logic [9:0] h, input logic [15:0] col,
                         input int exp_busy);
    clear_counts();
    build_model(v[1], sx, sy, dx, dy, w, h, col);
    start_cmd(v, sx, sy, dx, dy, w, h, col);
    @(negedge CLK);
    chk({nm, "_busy_start"}, 64'(BUSY_VRAMCTRL), 64'd1);
    wait_done(nm);
    finish_checks(nm, exp_busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [22:0] pat_adr [4];
    logic [22:0] bit_adr [6];
    int n;
    pat_adr = '{{14'd5, 9'd3}, {14'd5, 9'd4}, {14'd6, 9'd3}, {14'd6, 9'd4}};
    bit_adr = '{{14'd10, 9'd0}, {14'd20, 9'd100}, {14'd10, 9'd1},
                {14'd20, 9'd101}, {14'd10, 9'd2}, {14'd20, 9'd102}};
    RST_X = 1'b0; INIT = 1'b0; STARTBLT = 1'b0; VALID = 2'b00;
    OVA_SPOSX = '0; OVA_SPOSY = '0; OVA_DPOSX = '0; OVA_DPOSY = '0;
    OVA_WIDTH = '0; OVA_HEIGHT = '0; PAT_COLOR = '0;

    repeat (2) @(negedge CLK);
    chk("rst_req", 64'(VRAM_REQ), 64'd0);
    chk("rst_we", 64'(VRAM_WE), 64'd0);
    chk("rst_adr", 64'(VRAM_ADR), 64'd0);
    chk("rst_wdata", 64'(VRAM_WDATA), 64'd0);
    chk("rst_busy", 64'(BUSY_VRAMCTRL), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    @(posedge CLK); #1; RST_X = 1'b1;

    // Stray ACK while idle must be harmless.
    @(posedge CLK); #1; spur_ack = 1'b1;
    @(posedge CLK); #1; spur_ack = 1'b0;
    @(negedge CLK);
    chk("spur_ack_req", 64'(VRAM_REQ), 64'd0);
    chk("spur_ack_busy", 64'(BUSY_VRAMCTRL), 64'd0);

    // PatBlt 2x2 with one-cycle ACK latency: 1 setup + 4*(1 idle + 2 req) + 1 fin.
    dly_min = 1; dly_max = 1;
    run_blt("pat2x2", 2'b01, 9'd0, 14'd0, 9'd3, 14'd5, 9'd2, 10'd2, 16'hABCD, 14);
    chk("pat2x2_nacc", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("pat2x2_lit_adr", 64'(log_q[i].adr), 64'(pat_adr[i]));
      chk("pat2x2_lit_wdata", 64'(log_q[i].wdata), 64'h00000000ABCDABCD);
      chk("pat2x2_lit_we", 64'(log_q[i].we), 64'd1);
    end

    // BitBlt 3x1 with random 0-5 cycle latency.
    dly_min = 0; dly_max = 5;
    run_blt("bit3x1", 2'b10, 9'd0, 14'd10, 9'd100, 14'd20, 9'd3, 10'd1, 16'h0000, -1);
    chk("bit3x1_nacc", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("bit3x1_lit_adr", 64'(log_q[i].adr), 64'(bit_adr[i]));
      chk("bit3x1_lit_we", 64'(log_q[i].we), 64'(i % 2));
      if (i % 2 == 1) chk("bit3x1_lit_wdata", 64'(log_q[i].wdata), 64'(tag(bit_adr[i-1])));
    end

    // Zero width: no access, busy only for setup and fin.
    run_blt("zero_w", 2'b01, 9'd0, 14'd0, 9'd7, 14'd7, 9'd0, 10'd7, 16'h5555, 2);
    chk("zero_w_nacc", 64'(log_q.size()), 64'd0);

    // Column wrap at 511 stays on the same row.
    run_blt("wrap", 2'b01, 9'd0, 14'd0, 9'd511, 14'd9, 9'd2, 10'd1, 16'h1234, -1);
    chk("wrap_nacc", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("wrap_lit_adr0", 64'(log_q[0].adr), 64'({14'd9, 9'd511}));
      chk("wrap_lit_adr1", 64'(log_q[1].adr), 64'({14'd9, 9'd0}));
    end

    // INIT while a read is outstanding.
    clear_counts();
    hold = 1'b1;
    build_model(1'b1, 9'd5, 14'd7, 9'd8, 14'd9, 9'd4, 10'd2, 16'h0000);
    start_cmd(2'b10, 9'd5, 14'd7, 9'd8, 14'd9, 9'd4, 10'd2, 16'h0000);
    n = 0;
    while (!VRAM_REQ && n < 20) begin @(negedge CLK); n++; end
    chk("init_req_seen", 64'(VRAM_REQ), 64'd1);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1; INIT = 1'b1;
    @(posedge CLK); #1; INIT = 1'b0;
    @(negedge CLK);
    chk("init_req_drop", 64'(VRAM_REQ), 64'd0);
    chk("init_busy_drop", 64'(BUSY_VRAMCTRL), 64'd0);
    repeat (10) @(negedge CLK);
    chk("init_no_done", 64'(done_cnt), 64'd0);
    chk("init_one_access", 64'(log_q.size()), 64'd1);
    exp_q.delete();
    hold = 1'b0;
    dly_min = 0; dly_max = 3;
    run_blt("post_init", 2'b01, 9'd0, 14'd0, 9'd40, 14'd41, 9'd3, 10'd2, 16'hBEEF, -1);
    chk("post_init_nacc", 64'(log_q.size()), 64'd6);

    // Illegal VALID=11 pulses ERROR; VALID=00 is silently ignored.
    clear_counts();
    start_cmd(2'b11, 9'd1, 14'd1, 9'd1, 14'd1, 9'd1, 10'd1, 16'h0);
    @(negedge CLK);
    chk("illegal_error", 64'(ERROR), 64'd1);
    chk("illegal_busy", 64'(BUSY_VRAMCTRL), 64'd0);
    @(negedge CLK);
    chk("illegal_error_pulse", 64'(ERROR), 64'd0);
    start_cmd(2'b00, 9'd1, 14'd1, 9'd1, 14'd1, 9'd1, 10'd1, 16'h0);
    repeat (4) @(negedge CLK);
    chk("ignored_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("illegal_err_cnt", 64'(err_cnt), 64'd1);
    chk("ignored_nacc", 64'(log_q.size()), 64'd0);

    // STARTBLT during an active PatBlt must not disturb it.
    clear_counts();
    build_model(1'b0, 9'd0, 14'd0, 9'd50, 14'd60, 9'd3, 10'd2, 16'h1111);
    start_cmd(2'b01, 9'd0, 14'd0, 9'd50, 14'd60, 9'd3, 10'd2, 16'h1111);
    @(negedge CLK);
    chk("busy_inject_start", 64'(BUSY_VRAMCTRL), 64'd1);
    start_cmd(2'b01, 9'd0, 14'd0, 9'd200, 14'd300, 9'd5, 10'd5, 16'h2222);
    start_cmd(2'b11, 9'd0, 14'd0, 9'd200, 14'd300, 9'd5, 10'd5, 16'h2222);
    wait_done("inject");
    finish_checks("inject", -1);
    chk("inject_nacc", 64'(log_q.size()), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blt_vramctrl.md
Name: blt_vramctrl

Overview:
- VRAM access engine; consumes the clipped rectangle, VALID and STARTBLT produced by the draw-address stage.
- Scans the destination rectangle row-major and issues single-word VRAM write requests for PatBlt.
- For BitBlt, issues a source read followed by a destination write for every word.
- Drives BUSY_VRAMCTRL back to the address stage so the next command is held off until the blit finishes.

Parameters:
- X_W, 9, word-column width; VRAM address low field.
- Y_W, 14, row width; VRAM address high field.
- H_W, 10, height counter width.

Ports:
- CLK  input  1  clock.
- RST_X  input  1  reset; asynchronous, active-low.
- INIT  input  1  synchronous abort/clear.
- STARTBLT  input  1  one-cycle start pulse.
- VALID  input  2  01=PatBlt, 10=BitBlt; sampled with STARTBLT.
- OVA_SPOSX  input  X_W  source word column.
- OVA_SPOSY  input  Y_W  source row.
- OVA_DPOSX  input  X_W  destination word column.
- OVA_DPOSY  input  Y_W  destination row.
- OVA_WIDTH  input  X_W  width in words.
- OVA_HEIGHT  input  H_W  height in rows.
- PAT_COLOR  input  16  PatBlt pixel colour.
- VRAM_ACK  input  1  one-cycle completion of the current request.
- VRAM_RDATA  input  32  read data, valid with VRAM_ACK.
- VRAM_REQ  output  1  request.
- VRAM_WE  output  1  1=write, 0=read.
- VRAM_ADR  output  23  address {row, column}.
- VRAM_WDATA  output  32  write data.
- BUSY_VRAMCTRL  output  1  engine busy.
- DONE  output  1  one-cycle completion pulse.
- ERROR  output  1  one-cycle illegal-command pulse.

Behaviour:
- Reset and INIT:
  - All outputs are 0 and the FSM is in IDLE.
  - INIT has priority over every other event. It forces IDLE and drops REQ at the next edge. Any in-flight ACK is ignored. No DONE is generated.
- FSM states: IDLE, SETUP, RD, RDW, WR, WRW, FIN.
- IDLE:
  - STARTBLT with VALID=01 or 10 latches all OVA_* inputs, VALID and PAT_COLOR, then moves to SETUP.
  - STARTBLT with VALID=00 is ignored.
  - STARTBLT with VALID=11 produces ERROR=1 in the next cycle and stays in IDLE.
- STARTBLT outside IDLE is ignored; latched values are not disturbed.
- BUSY_VRAMCTRL is 1 from the SETUP cycle through the FIN cycle inclusive, and 0 in every other state.
- SETUP:
  - Clears column counter cx and row counter cy.
  - If WIDTH=0 or HEIGHT=0, goes to FIN with no VRAM access.
  - Otherwise goes to RD for BitBlt and WR for PatBlt.
- RD: REQ=1, WE=0, ADR={SPOSY+cy, SPOSX+cx}; then RDW.
- RDW: REQ held, address stable. On ACK, capture RDATA into the data register, drop REQ, go to WR.
- WR: REQ=1, WE=1, ADR={DPOSY+cy, DPOSX+cx}. WDATA is {PAT_COLOR, PAT_COLOR} for PatBlt, or the captured read word for BitBlt. Then WRW.
- WRW: REQ held. On ACK, drop REQ and advance the counters:
  - If cx=WIDTH-1, set cx=0 and cy=cy+1; otherwise cx=cx+1.
  - If the last word (cx=WIDTH-1 and cy=HEIGHT-1) was written, go to FIN; otherwise go to RD or WR.
- Request rules:
  - REQ stays asserted with ADR, WE and WDATA stable until the ACK cycle. REQ is 0 in the cycle after ACK.
  - At most one request is outstanding, with a minimum one idle cycle between requests.
- FIN: DONE=1 for one cycle, then IDLE.
- Address arithmetic:
  - Column sums are modulo 2^X_W (wrap, no carry into the row).
  - Row sums are modulo 2^Y_W.
- Access counts: PatBlt issues exactly WIDTH*HEIGHT writes. BitBlt issues WIDTH*HEIGHT read/write pairs, strictly alternating RD then WR.
- An ACK while REQ=0 is ignored.

Test Plan:
- PatBlt, DPOS=(3,5), W=2, H=2, COLOR=16'hABCD, ACK 1 cycle after REQ:
  - Writes go to {5,3}, {5,4}, {6,3}, {6,4}, each with WDATA 32'hABCDABCD.
  - DONE pulses once; BUSY is high from SETUP to FIN.
- BitBlt, SPOS=(0,10), DPOS=(100,20), W=3, H=1, RDATA=row-tagged values, random ACK delay 0-5:
  - Access order is R{10,0}, W{20,100}, R{10,1}, W{20,101}, R{10,2}, W{20,102}.
  - Each write data equals the preceding read data; REQ/ADR stay stable while waiting.
- W=0, H=7, PatBlt: no REQ at any time; BUSY high for 2 cycles (SETUP, FIN); DONE pulses once.
- DPOSX=511, W=2, H=1: second write address is {row, 0}; the row is unchanged.
- INIT asserted mid-BitBlt while in RDW:
  - REQ is 0 and BUSY is 0 the next cycle; no DONE.
  - A subsequent PatBlt completes normally.
- Illegal and ignored commands:
  - STARTBLT with VALID=11 gives an ERROR pulse, no BUSY.
  - STARTBLT during an active PatBlt is ignored; the original access count and addresses are unchanged.
